// File: rtl/zero_count_pattern_gen.sv
// Serial pattern generator: builds an 8-bit word holding min(in_count, 8) zeros packed into
// the LSBs, one bit per clock, then holds it under a valid/ready handshake.
module zero_count_pattern_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_count,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_word,
    output logic       out_sat,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StBuild, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] n_q, n_d;
    logic [7:0] word_q, word_d;
    logic       sat_q, sat_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        word_d  = word_q;
        sat_d   = sat_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sat_d   = (in_count > 4'd8);
                    n_d     = sat_d ? 4'd8 : in_count;
                    word_d  = 8'h00;
                    idx_d   = 3'd0;
                    state_d = StBuild;
                end
            end
            StBuild: begin
                // Bits below n are zeros, the rest ones.
                word_d[idx_q] = ({1'b0, idx_q} >= n_q);
                idx_d         = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            n_q     <= 4'd0;
            word_q  <= 8'h00;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            word_q  <= word_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = ~in_ready;
    assign out_valid = (state_q == StDone);
    assign out_word  = word_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_zero_count_pattern_gen.sv
// Randomized and directed checks of zero_count_pattern_gen against a word-level model
// built from the zero-count rule and the combinational zero counter it inverts.
module tb_zero_count_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_count = 4'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_word;
    logic       out_sat;
    logic       out_ready = 1'b0;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zero_count_pattern_gen dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_count (in_count),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_word (out_word),
        .out_sat  (out_sat),
        .out_ready(out_ready),
        .busy     (busy)
    );

    function automatic int sat_n(input int c);
        return (c > 8) ? 8 : c;
    endfunction

    function automatic logic [7:0] model_word(input int c);
        logic [31:0] t;
        t = 32'hFF << sat_n(c);
        return t[7:0];
    endfunction

    function automatic int zero_cnt(input logic [7:0] w);
        int z = 0;
        for (int i = 0; i < 8; i++) if (w[i] === 1'b0) z++;
        return z;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then lets one edge accept the request.
    task automatic send_req(input int c, output int waited);
        in_valid = 1'b1;
        in_count = 4'(c);
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_word !== 8'h00 ||
            out_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b busy=%b vld=%b word=%h sat=%b want 1 0 0 00 0",
                     in_ready, busy, out_valid, out_word, out_sat);
        end
    endtask

    task automatic test_basic();
        int w, lat;
        send_req(3, w);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        wait_valid(lat);
        total++;
        if (lat != 8) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=8", lat);
        end
        total++;
        if (out_word !== 8'hF8 || out_sat !== 1'b0 || zero_cnt(out_word) != 3) begin
            bad++;
            $display("FAIL basic_word got=%h sat=%b want=f8 sat=0", out_word, out_sat);
        end
        handshake();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int w, lat;
        for (int c = 0; c < 16; c++) begin
            send_req(c, w);
            if (c > 0) begin
                total++;
                if (w != 0) begin
                    bad++;
                    $display("FAIL b2b_accept_delay c=%0d got=%0d want=0", c, w);
                end
            end
            wait_valid(lat);
            total++;
            if (lat != 8 || out_word !== model_word(c) || out_sat !== (c > 8)) begin
                bad++;
                $display("FAIL b2b_word c=%0d got lat=%0d word=%h sat=%b want lat=8 word=%h sat=%b",
                         c, lat, out_word, out_sat, model_word(c), (c > 8));
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int w, lat;
        send_req(5, w);
        in_valid = 1'b1;
        in_count = 4'd2;
        wait_valid(lat);
        total++;
        if (lat != 8 || out_word !== 8'hE0) begin
            bad++;
            $display("FAIL bp_first got lat=%0d word=%h want lat=8 word=e0", lat, out_word);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_word !== 8'hE0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got vld=%b word=%h rdy=%b want 1 e0 0",
                         i, out_valid, out_word, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_word !== 8'hE0) begin
            bad++;
            $display("FAIL bp_no_reaccept got rdy=%b word=%h want 1 e0", in_ready, out_word);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_accept got busy=%b want 1", busy);
        end
        wait_valid(lat);
        total++;
        if (lat != 8 || out_word !== 8'hFC) begin
            bad++;
            $display("FAIL bp_second got lat=%0d word=%h want lat=8 word=fc", lat, out_word);
        end
        handshake();
    endtask

    task automatic test_reset_mid_build();
        int w, lat;
        send_req(6, w);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_word !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midbuild_reset got vld=%b word=%h busy=%b rdy=%b want 0 00 0 1",
                     out_valid, out_word, busy, in_ready);
        end
        send_req(1, w);
        wait_valid(lat);
        total++;
        if (lat != 8 || out_word !== 8'hFE) begin
            bad++;
            $display("FAIL midbuild_after got lat=%0d word=%h want lat=8 word=fe", lat, out_word);
        end
        handshake();
    endtask

    task automatic test_simultaneous();
        int w, lat;
        rst = 1'b1;
        in_valid = 1'b1;
        in_count = 4'd3;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_vs_accept got busy=%b rdy=%b want 0 1", busy, in_ready);
        end
        send_req(0, w);
        wait_valid(lat);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_word !== 8'h00 || in_ready !== 1'b1 || out_sat !== 1'b0) begin
            bad++;
            $display("FAIL rst_vs_handshake got vld=%b word=%h rdy=%b sat=%b want 0 00 1 0",
                     out_valid, out_word, in_ready, out_sat);
        end
    endtask

    task automatic test_random();
        int w, lat, c, gap;
        for (int k = 0; k < 40; k++) begin
            c = int'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) tick();
            send_req(c, w);
            wait_valid(lat);
            total++;
            if (lat != 8 || zero_cnt(out_word) != sat_n(c) || out_sat !== (c > 8)) begin
                bad++;
                $display("FAIL rand c=%0d got lat=%0d zeros=%0d sat=%b want lat=8 zeros=%0d sat=%b",
                         c, lat, zero_cnt(out_word), out_sat, sat_n(c), (c > 8));
            end
            repeat (gap) tick();
            total++;
            if (out_valid !== 1'b1 || out_word !== model_word(c)) begin
                bad++;
                $display("FAIL rand_hold c=%0d got vld=%b word=%h want 1 %h",
                         c, out_valid, out_word, model_word(c));
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_build();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
